// File: rtl/uart_line_rx.sv
// uart_line_rx: collects UART bytes into a CR/LF-terminated line and holds it for a consumer.
// Defining `UART_LINE_MATCH_EN builds the "ALINX" line comparator that drives match.
//
// state   | meaning
// IDLE    | waiting for the first non-terminator byte of a line
// COLLECT | storing bytes until terminator, overflow or idle timeout
// HOLD    | completed line frozen until line_ack
// DISCARD | overlong line, swallowing bytes up to the next terminator
module uart_line_rx #(
    parameter int DEPTH   = 32,
    parameter int TIMEOUT = 262143
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rdsig,
    input  logic [7:0] rxdata,
    input  logic       line_ack,
    input  logic [5:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       line_valid,
    output logic [6:0] line_len,
    output logic       overflow,
    output logic       timeout,
    output logic       dropped,
    output logic       match
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, HOLD, DISCARD} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic [7:0]    mem [DEPTH];
    logic          is_term, wr_en;
    logic          valid_nxt, ovf_nxt, to_nxt, drop_nxt;
    logic [6:0]    len_nxt;
    logic          unused_rd_addr;

    assign is_term        = (rxdata == 8'd13) || (rxdata == 8'd10);
    assign unused_rd_addr = ^rd_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // cnt is forced to 0 on every path back to IDLE, so it doubles as the write address
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        timer_nxt = '0;
        wr_en     = 1'b0;
        valid_nxt = line_valid;
        len_nxt   = line_len;
        ovf_nxt   = 1'b0;
        to_nxt    = 1'b0;
        drop_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (rdsig && !is_term) begin
                    wr_en     = 1'b1;
                    cnt_nxt   = CW'(1);
                    state_nxt = COLLECT;
                end
            end
            COLLECT: begin
                if (rdsig) begin
                    if (is_term) begin
                        valid_nxt = 1'b1;
                        len_nxt   = 7'(cnt);
                        state_nxt = HOLD;
                    end else if (cnt == CNT_FULL) begin
                        ovf_nxt   = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = DISCARD;
                    end else begin
                        wr_en   = 1'b1;
                        cnt_nxt = cnt + CW'(1);
                    end
                end else if (timer == TMR_LAST) begin
                    to_nxt    = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            HOLD: begin
                drop_nxt = rdsig;
                if (line_ack) begin
                    valid_nxt = 1'b0;
                    len_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end
            end
            DISCARD: begin
                if (rdsig) begin
                    if (is_term) state_nxt = IDLE;
                end else if (timer == TMR_LAST) begin
                    to_nxt    = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            timer      <= '0;
            line_valid <= 1'b0;
            line_len   <= '0;
            overflow   <= 1'b0;
            timeout    <= 1'b0;
            dropped    <= 1'b0;
            rd_data    <= '0;
        end else begin
            cnt        <= cnt_nxt;
            timer      <= timer_nxt;
            line_valid <= valid_nxt;
            line_len   <= len_nxt;
            overflow   <= ovf_nxt;
            timeout    <= to_nxt;
            dropped    <= drop_nxt;
            rd_data    <= mem[rd_addr[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[cnt[AW-1:0]] <= rxdata;
    end

`ifdef UART_LINE_MATCH_EN
    localparam logic [CW-1:0] CNT_FIVE = CW'(5);

    logic       match_flag;
    logic [7:0] match_byte;

    always_comb begin
        match_byte = 8'd0;
        case (cnt[2:0])
            3'd0:    match_byte = 8'd65;
            3'd1:    match_byte = 8'd76;
            3'd2:    match_byte = 8'd73;
            3'd3:    match_byte = 8'd78;
            3'd4:    match_byte = 8'd88;
            default: match_byte = 8'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_flag <= 1'b0;
            match      <= 1'b0;
        end else begin
            if (state == IDLE && rdsig && !is_term)
                match_flag <= (rxdata == 8'd65);
            else if (state == COLLECT && rdsig && !is_term)
                match_flag <= match_flag && (cnt < CNT_FIVE) && (rxdata == match_byte);
            if (state == COLLECT && rdsig && is_term)
                match <= match_flag && (cnt == CNT_FIVE);
            else if (state == HOLD && line_ack)
                match <= 1'b0;
        end
    end
`else
    assign match = 1'b0;
`endif

endmodule

// File: tb/tb_uart_line_rx.sv
// Randomized bench for uart_line_rx against a queue-based line model.
module tb_uart_line_rx;
    localparam int DEPTH   = 32;
    localparam int TIMEOUT = 40;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rdsig = 1'b0;
    logic [7:0] rxdata = 8'd0;
    logic       line_ack = 1'b0;
    logic [5:0] rd_addr = 6'd0;
    logic [7:0] rd_data;
    logic       line_valid;
    logic [6:0] line_len;
    logic       overflow, timeout, dropped, match;

    uart_line_rx #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .rdsig(rdsig), .rxdata(rxdata),
        .line_ack(line_ack), .rd_addr(rd_addr), .rd_data(rd_data),
        .line_valid(line_valid), .line_len(line_len), .overflow(overflow),
        .timeout(timeout), .dropped(dropped), .match(match)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: a queue of pending bytes plus "holding"/"discarding" flags.
    logic [7:0] q[$];
    logic [7:0] held [64];
    logic [7:0] alx [6] = '{8'd65, 8'd76, 8'd73, 8'd78, 8'd88, 8'd89};
    bit         holding = 0, discarding = 0;
    int         idle_cnt = 0, held_len = 0;
    bit         m_match = 0, e_ovf = 0, e_to = 0, e_drop = 0;

    function automatic bit line_is_alinx();
        if (q.size() != 5) return 0;
        for (int i = 0; i < 5; i++)
            if (q[i] !== alx[i]) return 0;
        return 1;
    endfunction

    task automatic model_step(input bit rd, input logic [7:0] d, input bit ack);
        bit term;
        term   = rd && (d == 8'd13 || d == 8'd10);
        e_ovf  = 0;
        e_to   = 0;
        e_drop = 0;
        if (holding) begin
            e_drop = rd;
            if (ack) begin
                holding  = 0;
                held_len = 0;
                m_match  = 0;
            end
        end else if (discarding) begin
            if (rd) begin
                idle_cnt = 0;
                if (term) discarding = 0;
            end else begin
                idle_cnt++;
                if (idle_cnt == TIMEOUT) begin
                    e_to = 1; discarding = 0; idle_cnt = 0;
                end
            end
        end else if (q.size() > 0) begin
            if (rd) begin
                idle_cnt = 0;
                if (term) begin
                    holding  = 1;
                    held_len = q.size();
                    foreach (q[i]) held[i] = q[i];
`ifdef UART_LINE_MATCH_EN
                    m_match = line_is_alinx();
`else
                    m_match = 0;
`endif
                    q.delete();
                end else if (q.size() == DEPTH) begin
                    e_ovf = 1; q.delete(); discarding = 1;
                end else begin
                    q.push_back(d);
                end
            end else begin
                idle_cnt++;
                if (idle_cnt == TIMEOUT) begin
                    e_to = 1; q.delete(); idle_cnt = 0;
                end
            end
        end else if (rd && !term) begin
            q.push_back(d);
            idle_cnt = 0;
        end
    endtask

    task automatic step(input bit rd, input logic [7:0] d, input bit ack, input logic [5:0] addr);
        bit         chk_rd;
        logic [7:0] exp_rd;
        rdsig    = rd;
        rxdata   = d;
        line_ack = ack;
        rd_addr  = addr;
        chk_rd   = holding && (int'(addr) < held_len);
        exp_rd   = held[addr];
        @(posedge clk);
        model_step(rd, d, ack);
        #1;
        check("line_valid", line_valid, holding);
        check("line_len", line_len, held_len);
        check("overflow", overflow, e_ovf);
        check("timeout", timeout, e_to);
        check("dropped", dropped, e_drop);
        check("match", match, m_match);
        if (chk_rd) check("rd_data", rd_data, exp_rd);
        rdsig    = 1'b0;
        line_ack = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        step(1, b, 0, 6'd0);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) step(0, 8'd0, 0, 6'd0);
    endtask

    task automatic do_reset();
        rdsig    = 1'b0;
        line_ack = 1'b0;
        rst_n    = 1'b0;
        #2;
        q.delete();
        holding = 0; discarding = 0; idle_cnt = 0; held_len = 0;
        m_match = 0; e_ovf = 0; e_to = 0; e_drop = 0;
        check("rst_rd_data", rd_data, 0);
        check("rst_valid", line_valid, 0);
        check("rst_len", line_len, 0);
        check("rst_ovf", overflow, 0);
        check("rst_to", timeout, 0);
        check("rst_drop", dropped, 0);
        check("rst_match", match, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset();

        // "abc" + CR, read back, ack
        send_str("abc");
        send(8'd13);
        check("abc_len", line_len, 3);
        step(0, 8'd0, 0, 6'd0);
        check("abc_rd0", rd_data, 97);
        step(0, 8'd0, 0, 6'd1);
        step(0, 8'd0, 0, 6'd2);
        check("abc_rd2", rd_data, 99);
        step(0, 8'd0, 1, 6'd0);
        check("abc_ack", line_valid, 0);

        // overflow at DEPTH+1 bytes
        for (int i = 0; i < DEPTH + 1; i++) send(8'(97 + (i % 26)));
        check("ovf_pulse", overflow, 1);
        send(8'd10);
        send_str("x");
        send(8'd13);
        check("ovf_next_len", line_len, 1);
        step(0, 8'd0, 1, 6'd0);

        // idle timeout, then a fresh line
        send_str("hi");
        wait_cycles(TIMEOUT + 2);
        send_str("ok");
        send(8'd10);
        step(0, 8'd0, 0, 6'd0);
        step(0, 8'd0, 0, 6'd1);
        step(0, 8'd0, 1, 6'd0);

        // byte together with ack while held
        send_str("ab");
        send(8'd13);
        step(1, "z", 1, 6'd0);
        check("drop_pulse", dropped, 1);
        send_str("q");
        send(8'd13);
        step(0, 8'd0, 0, 6'd0);
        step(0, 8'd0, 1, 6'd0);

        // bare terminators in IDLE
        send(8'd13); send(8'd10); send(8'd13);

        // match string variants
        send_str("ALINX");  send(8'd13); step(0, 8'd0, 1, 6'd0);
        send_str("ALINXX"); send(8'd13); step(0, 8'd0, 1, 6'd0);
        send_str("ALINY");  send(8'd13); step(0, 8'd0, 1, 6'd0);

        // reset in the middle of a line
        send_str("pq");
        do_reset();
        send_str("r");
        send(8'd10);
        step(0, 8'd0, 1, 6'd0);

        // random lines built from match-ish letters
        for (int n = 0; n < 60; n++) begin
            int len;
            len = $urandom_range(0, 7);
            if ($urandom_range(0, 9) == 0) len = $urandom_range(30, 34);
            for (int i = 0; i < len; i++) begin
                logic [7:0] b;
                b = ($urandom_range(0, 3) != 0) ? alx[(i < 5 && $urandom_range(0, 2) != 0) ? i : $urandom_range(0, 5)]
                                                : 8'($urandom_range(32, 126));
                send(b);
                if ($urandom_range(0, 3) == 0) wait_cycles($urandom_range(1, 2));
            end
            if ($urandom_range(0, 15) == 0) wait_cycles($urandom_range(TIMEOUT - 2, TIMEOUT + 1));
            send(($urandom_range(0, 1) == 0) ? 8'd13 : 8'd10);
            for (int i = 0; i < 4; i++) step($urandom_range(0, 5) == 0, 8'($urandom_range(32, 126)), 0, 6'($urandom_range(0, 7)));
            step(0, 8'd0, 1, 6'd0);
        end

        // free-running random traffic
        for (int n = 0; n < 3000; n++) begin
            bit         rd, ack;
            logic [7:0] d;
            rd = ($urandom_range(0, 99) < 35);
            case ($urandom_range(0, 9))
                0:       d = 8'd13;
                1:       d = 8'd10;
                2, 3, 4: d = alx[$urandom_range(0, 5)];
                default: d = 8'($urandom_range(32, 126));
            endcase
            ack = holding ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 19) == 0);
            step(rd, d, ack, 6'($urandom_range(0, 31)));
            if ($urandom_range(0, 199) == 0) wait_cycles($urandom_range(TIMEOUT - 2, TIMEOUT + 1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
